// File: rtl/tm1638_controller.sv
// tm1638_controller: continuously refreshes a TM1638 LED/key board
// (8 digits, 8 LEDs, brightness) and optionally scans its 8 keys.
// Define TM1638_KEY_READ_EN to include the key-read transaction.
module tm1638_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] digits,
    input  logic [7:0]  leds,
    input  logic [2:0]  brightness,
    output logic [7:0]  keys,
    output logic        keys_valid,
    output logic        tm1638_clk,
    output logic        tm1638_stb,
    input  logic        tm1638_dio_in,
    output logic        tm1638_dio_out,
    output logic        tm1638_dio_out_en
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);
`ifdef TM1638_KEY_READ_EN
    localparam logic [1:0] LAST_TXN = 2'd3;
`else
    localparam logic [1:0] LAST_TXN = 2'd2;
`endif

    typedef enum logic [2:0] {IDLE, START, SHIFT_OUT, READ_WAIT, SHIFT_IN, GAP, LATCH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;
    logic [4:0]    bit_q, bit_d;
    logic [4:0]    byte_q, byte_d;
    logic [1:0]    txn_q, txn_d;
    logic [7:0]    sh_q, sh_d;
    logic [63:0]   dig_q, dig_d;
    logic [7:0]    led_q, led_d;
    logic [2:0]    bri_q, bri_d;
    logic          en_q, en_d;
    logic          tick, full_end, frame_start;
    logic [4:0]    last_byte;
`ifdef TM1638_KEY_READ_EN
    logic [31:0]   rx_q, rx_d;
    logic [7:0]    keys_q, keys_d;
`endif

    // Byte sent at position idx of transaction txn (T1: address byte then 16 data bytes).
    function automatic logic [7:0] byte_for(input logic [1:0] txn, input logic [4:0] idx,
                                            input logic [63:0] dg, input logic [7:0] ld,
                                            input logic [2:0] br);
        logic [3:0] addr;
        addr = 4'(idx - 5'd1);
        case (txn)
            2'd0: byte_for = 8'h40;
            2'd1: begin
                if (idx == 5'd0)  byte_for = 8'hC0;
                else if (addr[0]) byte_for = {7'b0, ld[addr[3:1]]};
                else              byte_for = dg[{addr[3:1], 3'b000} +: 8];
            end
            2'd2:    byte_for = {5'b10001, br};
            default: byte_for = 8'h42;
        endcase
    endfunction

    assign tick      = (cnt_q == TERM);
    assign full_end  = tick && half_q;
    assign last_byte = (txn_q == 2'd1) ? 5'd16 : 5'd0;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            byte_q  <= '0;
            txn_q   <= '0;
            sh_q    <= '0;
            dig_q   <= '0;
            led_q   <= '0;
            bri_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            txn_q   <= txn_d;
            sh_q    <= sh_d;
            dig_q   <= dig_d;
            led_q   <= led_d;
            bri_q   <= bri_d;
            en_q    <= en_d;
        end
    end

`ifdef TM1638_KEY_READ_EN
    // Key shift register and latched key state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_q   <= '0;
            keys_q <= '0;
        end else begin
            rx_q   <= rx_d;
            keys_q <= keys_d;
        end
    end
    assign keys       = keys_q;
    assign keys_valid = (state_q == LATCH);
`else
    logic unused_dio;
    assign unused_dio = tm1638_dio_in;
    assign keys       = '0;
    assign keys_valid = 1'b0;
`endif

    // Next-state and datapath: half-period timer, bit/byte sequencing, frame snapshot.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        half_d      = tick ? ~half_q : half_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        txn_d       = txn_q;
        sh_d        = sh_q;
        dig_d       = dig_q;
        led_d       = led_q;
        bri_d       = bri_q;
        en_d        = 1'b1;
        frame_start = 1'b0;
`ifdef TM1638_KEY_READ_EN
        rx_d        = rx_q;
        keys_d      = keys_q;
`endif
        case (state_q)
            IDLE: if (full_end) frame_start = 1'b1;
            START: if (tick) state_d = SHIFT_OUT;
            SHIFT_OUT: if (full_end) begin
                bit_d = bit_q + 5'd1;
                sh_d  = {1'b0, sh_q[7:1]};
                if (bit_q[2:0] == 3'd7) begin
                    bit_d = '0;
                    if (byte_q == last_byte) begin
`ifdef TM1638_KEY_READ_EN
                        state_d = (txn_q == 2'd3) ? READ_WAIT : GAP;
`else
                        state_d = GAP;
`endif
                    end else begin
                        byte_d = byte_q + 5'd1;
                        sh_d   = byte_for(txn_q, byte_q + 5'd1, dig_q, led_q, bri_q);
                    end
                end
            end
`ifdef TM1638_KEY_READ_EN
            READ_WAIT: if (full_end) begin
                state_d = SHIFT_IN;
                bit_d   = '0;
            end
            SHIFT_IN: begin
                // Sample in the last cycle of the low half, just before clk rises.
                if (tick && !half_q) rx_d = {tm1638_dio_in, rx_q[31:1]};
                if (full_end) begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd31) state_d = GAP;
                end
            end
            LATCH: frame_start = 1'b1;
`endif
            GAP: if (full_end) begin
                if (txn_q == LAST_TXN) begin
`ifdef TM1638_KEY_READ_EN
                    state_d = LATCH;
                    for (int b = 0; b < 4; b++) begin
                        keys_d[b]     = rx_q[8*b];
                        keys_d[b + 4] = rx_q[8*b + 4];
                    end
`else
                    frame_start = 1'b1;
`endif
                end else begin
                    state_d = START;
                    txn_d   = txn_q + 2'd1;
                    byte_d  = '0;
                    bit_d   = '0;
                    sh_d    = byte_for(txn_q + 2'd1, 5'd0, dig_q, led_q, bri_q);
                end
            end
            default: state_d = IDLE;
        endcase
        // Inputs are frozen for the whole frame at its first STB fall.
        if (frame_start) begin
            state_d = START;
            txn_d   = '0;
            byte_d  = '0;
            bit_d   = '0;
            sh_d    = 8'h40;
            dig_d   = digits;
            led_d   = leds;
            bri_d   = brightness;
        end
        if (state_d != state_q) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end
    end

    // Pin outputs decoded from registered state.
    always_comb begin
        tm1638_clk        = 1'b1;
        tm1638_stb        = 1'b1;
        tm1638_dio_out    = 1'b0;
        tm1638_dio_out_en = en_q;
        case (state_q)
            START: tm1638_stb = 1'b0;
            SHIFT_OUT: begin
                tm1638_stb     = 1'b0;
                tm1638_clk     = half_q;
                tm1638_dio_out = sh_q[0];
            end
            READ_WAIT: begin
                tm1638_stb        = 1'b0;
                tm1638_dio_out_en = 1'b0;
            end
            SHIFT_IN: begin
                tm1638_stb        = 1'b0;
                tm1638_clk        = half_q;
                tm1638_dio_out_en = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_tm1638_controller.sv
// Bench for tm1638_controller: serial monitor + byte/length/key scoreboard.
module tb_tm1638_controller;
    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] digits = '0;
    logic [7:0]  leds = '0;
    logic [2:0]  brightness = '0;
    logic [7:0]  keys;
    logic        keys_valid, tclk, stb, dio_out, dio_en;
    logic        dio_in = 1'b0;

    tm1638_controller #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .leds(leds), .brightness(brightness),
        .keys(keys), .keys_valid(keys_valid), .tm1638_clk(tclk), .tm1638_stb(stb),
        .tm1638_dio_in(dio_in), .tm1638_dio_out(dio_out), .tm1638_dio_out_en(dio_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [7:0] exp_q[$];
    int         exp_len[$];
    logic [7:0] exp_keys[$];
    logic prev_tclk = 1'b1, prev_stb = 1'b1, prev_kv = 1'b0;
    logic [7:0]  cur = '0;
    logic [31:0] rd_word = '0;
    int nbits = 0, nbytes = 0, rd_idx = 0, stb_falls = 0, wr_rises = 0, en_low = 0, kv_seen = 0;

    function automatic logic [7:0] key_model(input logic [31:0] w);
        logic [7:0] k;
        for (int b = 0; b < 4; b++) begin
            k[b]     = w[8*b];
            k[b + 4] = w[8*b + 4];
        end
        return k;
    endfunction

    // One clock: sample pins after the edge, decode serial traffic, model key reads.
    task automatic tick();
        logic [7:0] e;
        int l;
        @(posedge clk); #1;
        if (prev_stb && !stb) begin
            nbits = 0; nbytes = 0; rd_idx = 0; stb_falls++;
        end
        if (!stb && dio_en && !prev_tclk && tclk) begin
            cur = {dio_out, cur[7:1]};
            nbits++; wr_rises++;
            if (nbits == 8) begin
                nbits = 0; nbytes++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (cur !== e) begin
                        n_err++;
                        $display("FAIL byte: got %02h expected %02h", cur, e);
                    end
                end
            end
        end
        if (!stb && !dio_en) begin
            en_low++;
            if (prev_tclk && !tclk) begin
                dio_in = rd_word[rd_idx[4:0]];
                rd_idx++;
            end
        end
        if (!prev_stb && stb && exp_len.size() > 0) begin
            l = exp_len.pop_front();
            n_vec++;
            if (nbytes != l) begin
                n_err++;
                $display("FAIL txn_len: got %0d bytes expected %0d", nbytes, l);
            end
        end
        if (keys_valid) begin
            kv_seen++;
            if (exp_keys.size() > 0) begin
                e = exp_keys.pop_front();
                n_vec++;
                if (keys !== e) begin
                    n_err++;
                    $display("FAIL keys: got %02h expected %02h", keys, e);
                end
            end
        end
        if (prev_kv) begin
            n_vec++;
            if (keys_valid !== 1'b0) begin
                n_err++;
                $display("FAIL kv_width: keys_valid high %0d expected 0 on second cycle", keys_valid);
            end
        end
        prev_tclk = tclk; prev_stb = stb; prev_kv = keys_valid;
    endtask

    task automatic push_frame(input logic [63:0] dg, input logic [7:0] ld, input logic [2:0] br);
        exp_q.push_back(8'h40); exp_len.push_back(1);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(dg[8*i +: 8]);
            exp_q.push_back({7'b0, ld[i]});
        end
        exp_len.push_back(17);
        exp_q.push_back(8'h88 | {5'b0, br}); exp_len.push_back(1);
`ifdef TM1638_KEY_READ_EN
        exp_q.push_back(8'h42); exp_len.push_back(1);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) tick();
        stb_falls = 0; wr_rises = 0; en_low = 0; kv_seen = 0;
    endtask

    task automatic wait_sb(input int maxc);
        int n = 0;
        while ((exp_q.size() > 0 || exp_len.size() > 0 || exp_keys.size() > 0) && n < maxc) begin
            tick(); n++;
        end
        n_vec++;
        if (exp_q.size() > 0 || exp_len.size() > 0 || exp_keys.size() > 0) begin
            n_err++;
            $display("FAIL sb_timeout: %0d bytes %0d lens %0d keys pending, expected 0 after %0d cycles",
                     exp_q.size(), exp_len.size(), exp_keys.size(), maxc);
            exp_q.delete(); exp_len.delete(); exp_keys.delete();
        end
    endtask

    task automatic wait_falls(input int k, input int maxc);
        int n = 0;
        while (stb_falls < k && n < maxc) begin tick(); n++; end
        if (stb_falls < k) begin
            n_vec++; n_err++;
            $display("FAIL stb_wait: saw %0d STB falls expected %0d", stb_falls, k);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        digits = '0; leds = '0; brightness = '0;
        do_reset();
        n_vec += 6;
        if (tclk !== 1'b1)       begin n_err++; $display("FAIL rst_clk: got %b expected 1", tclk); end
        if (stb !== 1'b1)        begin n_err++; $display("FAIL rst_stb: got %b expected 1", stb); end
        if (dio_en !== 1'b0)     begin n_err++; $display("FAIL rst_en: got %b expected 0", dio_en); end
        if (dio_out !== 1'b0)    begin n_err++; $display("FAIL rst_dio: got %b expected 0", dio_out); end
        if (keys !== 8'h00)      begin n_err++; $display("FAIL rst_keys: got %02h expected 00", keys); end
        if (keys_valid !== 1'b0) begin n_err++; $display("FAIL rst_kv: got %b expected 0", keys_valid); end
        rst_n = 1'b1;
        do begin tick(); n++; end while (stb && n < 100);
        n_vec++;
        if (n != 2*CD) begin n_err++; $display("FAIL first_stb: fell after %0d cycles expected %0d", n, 2*CD); end
    endtask

    // Cycle-accurate trace of T0 followed by its gap and the next STB fall.
    task automatic test_cmd_timing();
        logic [7:0] cmd;
        logic es, ec, ed;
        cmd = 8'h40;
        do_reset();
        rst_n = 1'b1;
        wait_falls(1, 100);
        for (int c = 0; c <= 19*CD; c++) begin
            es = 1'b0; ec = 1'b1; ed = 1'b0;
            if (c >= CD && c < 17*CD) begin
                ec = (((c - CD) % (2*CD)) >= CD);
                ed = cmd[(c - CD) / (2*CD)];
            end else if (c >= 17*CD && c < 19*CD) begin
                es = 1'b1;
            end
            n_vec++;
            if (stb !== es || tclk !== ec || (!ec && dio_out !== ed) || (!es && dio_en !== 1'b1)) begin
                n_err++;
                $display("FAIL t0_trace c=%0d: got stb=%b clk=%b dio=%b en=%b expected stb=%b clk=%b dio=%b en=1",
                         c, stb, tclk, dio_out, dio_en, es, ec, ed);
            end
            if (c < 19*CD) tick();
        end
    endtask

    task automatic test_data();
        do_reset();
        digits = 64'h0000_0000_0000_003F; leds = 8'h01; brightness = 3'd0;
        push_frame(digits, leds, brightness);
        rst_n = 1'b1;
        wait_sb(4000);
    endtask

    task automatic test_brightness();
        do_reset();
        digits = {$urandom, $urandom}; leds = 8'($urandom); brightness = 3'd5;
        push_frame(digits, leds, brightness);
        rst_n = 1'b1;
        wait_sb(4000);
    endtask

    task automatic test_snapshot();
        logic [63:0] db;
        logic [7:0]  lb;
        do_reset();
        digits = 64'h0123_4567_89AB_CDEF; leds = 8'hA5; brightness = 3'd7;
        db = 64'hFEDC_BA98_7654_3210; lb = 8'h5A;
        push_frame(digits, leds, brightness);
        push_frame(db, lb, 3'd2);
        rst_n = 1'b1;
        wait_falls(2, 200);
        repeat (20) tick();
        digits = db; leds = lb; brightness = 3'd2;
        wait_sb(8000);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        digits = 64'h7766_5544_3322_1100; leds = 8'hFF; brightness = 3'd1;
        rst_n = 1'b1;
        wait_falls(2, 200);
        wr_rises = 0;
        while (wr_rises < 32 && n < 2000) begin tick(); n++; end
        rst_n = 1'b0;
        tick();
        n_vec += 4;
        if (stb !== 1'b1)     begin n_err++; $display("FAIL mid_stb: got %b expected 1", stb); end
        if (tclk !== 1'b1)    begin n_err++; $display("FAIL mid_clk: got %b expected 1", tclk); end
        if (dio_en !== 1'b0)  begin n_err++; $display("FAIL mid_en: got %b expected 0", dio_en); end
        if (dio_out !== 1'b0) begin n_err++; $display("FAIL mid_dio: got %b expected 0", dio_out); end
        digits = 64'h0807_0605_0403_0201; leds = 8'h3C; brightness = 3'd4;
        push_frame(digits, leds, brightness);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_sb(4000);
    endtask

`ifdef TM1638_KEY_READ_EN
    task automatic test_keys();
        logic [31:0] pats [2];
        pats[0] = 32'h0010_0001;
        pats[1] = 32'hEE01_10EF;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            rd_word = pats[p];
            exp_keys.push_back(key_model(pats[p]));
            rst_n = 1'b1;
            wait_falls(4, 2000);
            en_low = 0;
            wait_sb(2000);
            n_vec++;
            if (en_low != 2*CD + 64*CD) begin
                n_err++;
                $display("FAIL read_en_low: %0d cycles expected %0d", en_low, 2*CD + 64*CD);
            end
            repeat (2) tick();
        end
    endtask
`else
    task automatic test_no_keys();
        do_reset();
        digits = 64'hDEAD_BEEF_0BAD_F00D; leds = 8'h81; brightness = 3'd3;
        push_frame(digits, leds, brightness);
        push_frame(digits, leds, brightness);
        rst_n = 1'b1;
        wait_sb(6000);
        n_vec += 3;
        if (en_low != 0)  begin n_err++; $display("FAIL nokey_en: %0d cycles released expected 0", en_low); end
        if (kv_seen != 0) begin n_err++; $display("FAIL nokey_kv: %0d pulses expected 0", kv_seen); end
        if (keys !== 8'h00) begin n_err++; $display("FAIL nokey_keys: got %02h expected 00", keys); end
    endtask
`endif

    initial begin
        test_reset();
        test_cmd_timing();
        test_data();
        test_brightness();
        test_snapshot();
        test_reset_mid();
`ifdef TM1638_KEY_READ_EN
        test_keys();
`else
        test_no_keys();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
